// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - passive I2C bus monitor with condition, byte and error reporting
//
// Purpose: watches SCL/SDA without ever driving them. Both pads are
// synchronised and deglitched. The monitor then reports START, repeated START
// and STOP, reassembles bytes with their ACK bit, and flags protocol errors
// and SCL-low timeouts.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   en_i                   monitor enable (sync/filter keep running when low)
//   scl_pad_i, sda_pad_i   raw asynchronous pad inputs
//   start_o, rstart_o      one-cycle pulses: START while idle / while busy
//   stop_o                 one-cycle pulse: STOP
//   busy_o                 level: bus between START and STOP
//   byte_vld_o, byte_o     pulse + held byte after the 8th bit (MSB first)
//   ack_vld_o, ack_o       pulse + held 9th bit (0 = ACK)
//   err_o, err_code_o      pulse + held code: 01 misplaced, 10 simultaneous edge, 11 timeout
//   timeout_o              level: SCL held low too long while busy
module i2c_bus_monitor #(
    parameter int FILTER_LEN  = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       en_i,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       start_o,
    output logic       rstart_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
    output logic       ack_vld_o,
    output logic       ack_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic       timeout_o
);

    localparam logic [3:0]      FLT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYC);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    // Index 0 = SCL, index 1 = SDA throughout the front end.
    logic [1:0]      sync1_q, sync2_q, filt_q, prev_q;
    logic [1:0][3:0] flt_cnt_q;

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q;
    logic [6:0]      shift_q;
    logic [TO_W-1:0] to_cnt_q;

    logic scl_f, sda_f;
    logic scl_rise, scl_edge, sda_rise, sda_fall, sda_edge;
    logic start_det, stop_det, simul_err, misplaced, bit_cap, to_run, to_hit;

    // Front end: sync, filter and edge history run regardless of en_i so that
    // re-enabling never sees a stale level as a fresh edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            prev_q    <= 2'b11;
            flt_cnt_q <= '0;
        end else begin
            sync1_q <= {sda_pad_i, scl_pad_i};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    flt_cnt_q[i] <= '0;
                end else if (flt_cnt_q[i] == FLT_LAST) begin
                    // This is the FILTER_LEN-th consecutive differing sample.
                    filt_q[i]    <= sync2_q[i];
                    flt_cnt_q[i] <= '0;
                end else begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise = filt_q[0] & ~prev_q[0];
    assign scl_edge = filt_q[0] ^ prev_q[0];
    assign sda_rise = filt_q[1] & ~prev_q[1];
    assign sda_fall = ~filt_q[1] & prev_q[1];
    assign sda_edge = filt_q[1] ^ prev_q[1];

    // SCL must be steadily high: an SCL edge in the same cycle makes the SDA
    // edge ambiguous, and that case is reported separately while busy.
    assign start_det = sda_fall & scl_f & ~scl_edge;
    assign stop_det  = sda_rise & scl_f & ~scl_edge;
    assign simul_err = scl_edge & sda_edge & busy_o;
    assign misplaced = (start_det | stop_det) & (bit_cnt_q != 4'd0);
    assign bit_cap   = busy_o & scl_rise & ~sda_edge;
    assign to_run    = busy_o & ~scl_f;
    assign to_hit    = to_run & (to_cnt_q == TO_LAST);

    // Bus state: state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus state: next state
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_BUSY;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end
    end

    // Bus state: outputs
    always_comb begin
        busy_o = (state_q == ST_BUSY);
    end

    // Event pulses, byte assembly, timeout and error reporting.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_o    <= 1'b0;
            rstart_o   <= 1'b0;
            stop_o     <= 1'b0;
            byte_vld_o <= 1'b0;
            byte_o     <= 8'h00;
            ack_vld_o  <= 1'b0;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
            timeout_o  <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            to_cnt_q   <= '0;
        end else begin
            start_o    <= 1'b0;
            rstart_o   <= 1'b0;
            stop_o     <= 1'b0;
            byte_vld_o <= 1'b0;
            ack_vld_o  <= 1'b0;
            err_o      <= 1'b0;
            if (!en_i) begin
                bit_cnt_q <= '0;
                to_cnt_q  <= '0;
                timeout_o <= 1'b0;
            end else begin
                start_o  <= start_det & ~busy_o;
                rstart_o <= start_det & busy_o;
                stop_o   <= stop_det;

                if (start_det || stop_det) begin
                    bit_cnt_q <= '0;
                end else if (bit_cap) begin
                    if (bit_cnt_q == 4'd8) begin
                        ack_o     <= sda_f;
                        ack_vld_o <= 1'b1;
                        bit_cnt_q <= '0;
                    end else begin
                        shift_q   <= {shift_q[5:0], sda_f};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            byte_o     <= {shift_q, sda_f};
                            byte_vld_o <= 1'b1;
                        end
                    end
                end

                // Saturating so the timeout error fires exactly once per low phase.
                if (!to_run) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end

                if (scl_rise || stop_det) begin
                    timeout_o <= 1'b0;
                end else if (to_hit) begin
                    timeout_o <= 1'b1;
                end

                if (to_hit || misplaced || simul_err) begin
                    err_o      <= 1'b1;
                    err_code_o <= to_hit ? 2'b11 : (misplaced ? 2'b01 : 2'b10);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb/tb_i2c_bus_monitor.sv - scoreboard bench for i2c_bus_monitor
module tb_i2c_bus_monitor;

    localparam int FL = 3;
    localparam int TO = 100;

    localparam int K_ERR    = 0;
    localparam int K_START  = 1;
    localparam int K_RSTART = 2;
    localparam int K_STOP   = 3;
    localparam int K_BYTE   = 4;
    localparam int K_ACK    = 5;

    logic       clk = 1'b0;
    logic       rst, en, scl_pad, sda_pad;
    logic       start_o, rstart_o, stop_o, busy_o, byte_vld_o, ack_vld_o, ack_o;
    logic       err_o, timeout_o;
    logic [7:0] byte_o;
    logic [1:0] err_code_o;

    always #5 clk = ~clk;

    i2c_bus_monitor #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .TO_W(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .en_i       (en),
        .scl_pad_i  (scl_pad),
        .sda_pad_i  (sda_pad),
        .start_o    (start_o),
        .rstart_o   (rstart_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o),
        .byte_vld_o (byte_vld_o),
        .byte_o     (byte_o),
        .ack_vld_o  (ack_vld_o),
        .ack_o      (ack_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .timeout_o  (timeout_o)
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // Protocol-level reference model: bus line levels plus I2C transaction state.
    logic m_scl, m_sda, m_en;
    int   m_busy, m_bits, m_shift;
    int   last_byte, last_ack, last_code;

    function automatic string kname(int k);
        case (k)
            K_ERR:    return "err";
            K_START:  return "start";
            K_RSTART: return "rstart";
            K_STOP:   return "stop";
            K_BYTE:   return "byte";
            default:  return "ack";
        endcase
    endfunction

    task automatic push(int k, int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
        if (k == K_ERR)  last_code = v;
        if (k == K_BYTE) last_byte = v;
        if (k == K_ACK)  last_ack  = v;
    endtask

    task automatic model_apply(logic ns, logic nd);
        logic scl_ch, sda_ch;
        scl_ch = (ns != m_scl);
        sda_ch = (nd != m_sda);
        if (m_en) begin
            if (scl_ch && sda_ch) begin
                if (m_busy != 0) push(K_ERR, 2);
            end else if (sda_ch && m_scl) begin
                if (m_bits != 0) push(K_ERR, 1);
                if (!nd) begin
                    push((m_busy != 0) ? K_RSTART : K_START, 0);
                    m_busy = 1;
                end else begin
                    push(K_STOP, 0);
                    m_busy = 0;
                end
                m_bits = 0;
            end else if (scl_ch && ns && m_busy != 0) begin
                if (m_bits == 8) begin
                    push(K_ACK, int'(nd));
                    m_bits = 0;
                end else begin
                    m_shift = (m_shift * 2 + int'(nd)) % 256;
                    m_bits  = m_bits + 1;
                    if (m_bits == 8) push(K_BYTE, m_shift);
                end
            end
        end
        m_scl = ns;
        m_sda = nd;
    endtask

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic got(int k, int v);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got %s %0h, expected no event", kname(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                fails++;
                $display("FAIL event: got %s %0h, expected %s %0h", kname(k), v, kname(e.kind), e.val);
            end
        end
    endtask

    // Monitor: every pulse the DUT presents is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err_o)      got(K_ERR, int'(err_code_o));
                if (start_o)    got(K_START, 0);
                if (rstart_o)   got(K_RSTART, 0);
                if (stop_o)     got(K_STOP, 0);
                if (byte_vld_o) got(K_BYTE, int'(byte_o));
                if (ack_vld_o)  got(K_ACK, int'(ack_o));
            end
        end
    end

    function automatic int hr();
        return int'($urandom_range(6, 14));
    endfunction

    function automatic int outs();
        return int'({start_o, rstart_o, stop_o, busy_o, byte_vld_o, ack_vld_o, ack_o,
                     err_o, timeout_o, err_code_o, byte_o});
    endfunction

    task automatic bus_set(logic s, logic d, int hold);
        model_apply(s, d);
        scl_pad = s;
        sda_pad = d;
        repeat (hold) @(negedge clk);
    endtask

    task automatic set_r(logic s, logic d);
        bus_set(s, d, hr());
    endtask

    task automatic do_start();
        if (!m_scl) begin
            set_r(1'b0, 1'b1);
            set_r(1'b1, 1'b1);
        end else if (!m_sda) begin
            set_r(1'b0, 1'b0);
            set_r(1'b0, 1'b1);
            set_r(1'b1, 1'b1);
        end
        set_r(1'b1, 1'b0);
    endtask

    task automatic do_stop();
        if (!m_scl) begin
            set_r(1'b0, 1'b0);
            set_r(1'b1, 1'b0);
        end else if (m_sda) begin
            set_r(1'b0, 1'b1);
            set_r(1'b0, 1'b0);
            set_r(1'b1, 1'b0);
        end
        set_r(1'b1, 1'b1);
    endtask

    task automatic send_bit(logic b);
        set_r(1'b0, m_sda);
        set_r(1'b0, b);
        set_r(1'b1, b);
    endtask

    task automatic send_byte(int v, logic a);
        for (int i = 7; i >= 0; i--) send_bit(1'((v >> i) & 1));
        send_bit(a);
    endtask

    task automatic glitch(int n);
        if (n >= FL) begin
            model_apply(1'b1, 1'b0);
            model_apply(1'b1, 1'b1);
        end
        sda_pad = 1'b0;
        repeat (n) @(negedge clk);
        sda_pad = 1'b1;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rise, nb, r, k;
        rst = 1'b1; en = 1'b1; scl_pad = 1'b1; sda_pad = 1'b1;
        m_scl = 1'b1; m_sda = 1'b1; m_en = 1'b1;
        m_busy = 0; m_bits = 0; m_shift = 0;
        last_byte = 0; last_ack = 0; last_code = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Latency of START from the pad, then a repeated START.
        model_apply(1'b1, 1'b0);
        sda_pad = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 5) chk("start_cycle5", int'(start_o), 0);
            if (c == 6) chk("start_cycle6", int'(start_o), 1);
            if (c == 7) chk("busy_cycle7", int'(busy_o), 1);
        end
        set_r(1'b0, 1'b0);
        set_r(1'b0, 1'b1);
        set_r(1'b1, 1'b1);
        set_r(1'b1, 1'b0);
        do_stop();
        repeat (4) @(negedge clk);
        chk("busy_after_stop", int'(busy_o), 0);

        // Plain byte 0xA5 with ACK.
        do_start();
        send_byte(8'hA5, 1'b0);
        do_stop();
        repeat (4) @(negedge clk);
        chk("byte_a5", int'(byte_o), 8'hA5);
        chk("ack_a5", int'(ack_o), 0);
        chk("busy_a5", int'(busy_o), 0);

        // Deglitching: too short, then just long enough.
        glitch(FL - 1);
        chk("glitch_short_busy", int'(busy_o), 0);
        glitch(FL);
        chk("glitch_long_busy", int'(busy_o), 0);

        // STOP inside a byte, then a clean byte.
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        do_stop();
        repeat (4) @(negedge clk);
        chk("misplaced_code", int'(err_code_o), 1);
        do_start();
        send_byte(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        do_stop();

        // SCL-low timeout.
        do_start();
        push(K_ERR, 3);
        model_apply(1'b0, 1'b0);
        scl_pad = 1'b0;
        rise = -1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (timeout_o && rise < 0) rise = c;
        end
        chk("timeout_rise_cycle", rise, FL + 2 + TO);
        chk("timeout_level", int'(timeout_o), 1);
        chk("timeout_code", int'(err_code_o), 3);
        bus_set(1'b1, 1'b0, hr());
        repeat (4) @(negedge clk);
        chk("timeout_cleared", int'(timeout_o), 0);
        do_stop();

        // Simultaneous edge while busy, then reset mid-byte.
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        bus_set(1'b0, 1'b1, hr());
        repeat (4) @(negedge clk);
        chk("simul_code", int'(err_code_o), 2);
        send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", outs(), 0);
        rst = 1'b0;
        m_busy = 0; m_bits = 0; m_shift = 0;
        last_byte = 0; last_ack = 0; last_code = 0;
        repeat (6) @(negedge clk);
        do_start();
        send_byte(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        do_stop();

        // Disable mid-transfer: no pulses, busy drops, held values stay.
        do_start();
        send_bit(1'b0);
        send_bit(1'b1);
        en = 1'b0;
        m_en = 1'b0; m_busy = 0; m_bits = 0;
        repeat (3) @(negedge clk);
        chk("disabled_busy", int'(busy_o), 0);
        set_r(1'b1, 1'b0);
        set_r(1'b1, 1'b1);
        set_r(1'b0, 1'b1);
        set_r(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("disabled_byte_hold", int'(byte_o), last_byte);
        chk("disabled_ack_hold", int'(ack_o), last_ack);
        chk("disabled_code_hold", int'(err_code_o), last_code);
        en = 1'b1;
        m_en = 1'b1;
        repeat (10) @(negedge clk);
        do_start();
        send_byte(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        do_stop();

        // Randomised traffic with occasional aborted bytes and edge collisions.
        for (int t = 0; t < 25; t++) begin
            do_start();
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) begin
                    k = int'($urandom_range(1, 7));
                    for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)));
                    do_start();
                end else if (r == 1) begin
                    send_bit(1'($urandom_range(0, 1)));
                    bus_set(~m_scl, ~m_sda, hr());
                end else begin
                    send_byte(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                end
            end
            do_stop();
            repeat ($urandom_range(2, 10)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_busy", int'(busy_o), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
